// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that grants one of NUM_REQ requesters access to the
//   write side of a FIFO for a burst of up to MAX_BURST beats (halved when
//   the FIFO reports half full at grant time).
//
// Ports
//   wclk        in   FIFO write-side clock, rising edge
//   wrst_n      in   asynchronous active-low reset
//   req         in   per-requester level write request
//   req_data    in   packed requester data, slice i belongs to requester i
//   full        in   FIFO full flag, stalls the current burst
//   half_full   in   FIFO half-full flag, sampled on the grant edge
//   write_error in   FIFO write-error pulse
//   gnt         out  one-hot registered grant, zero when idle
//   ack         out  one-hot beat accept for the granted requester
//   w_en        out  FIFO write enable
//   data_in     out  FIFO write data (granted slice, zero when idle)
//   busy        out  high while a burst is in progress
//   err_cnt     out  saturating count of write_error pulses

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    input  logic                          half_full,
    input  logic                          write_error,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy,
    output logic [7:0]                    err_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BW    = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [IDX_W-1:0]   last_gnt, last_gnt_nxt;
    logic [BW-1:0]      beat_cnt, beat_cnt_nxt;
    logic [BW-1:0]      limit;
    logic               half_q, half_q_nxt;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    // Round-robin search. Walking the offsets from farthest to nearest lets
    // the nearest asserted requester (after last_gnt) overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_gnt;
        cand      = last_gnt;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign limit = half_q ? BW'(MAX_BURST / 2) : BW'(MAX_BURST);
    assign busy  = (state == BURST);
    assign w_en  = (state == BURST) && req[gnt_idx] && !full;
    assign ack   = w_en ? gnt : '0;

    // One-hot AND-OR mux: gnt is all zero when idle, so data_in is zero too.
    always_comb begin
        data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                data_in = data_in | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_idx_nxt  = gnt_idx;
        last_gnt_nxt = last_gnt;
        beat_cnt_nxt = beat_cnt;
        half_q_nxt   = half_q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt    = BURST;
                    gnt_nxt      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    gnt_idx_nxt  = win_idx;
                    beat_cnt_nxt = '0;
                    half_q_nxt   = half_full;
                end
            end
            BURST: begin
                if (!req[gnt_idx] || (w_en && (beat_cnt == limit - 1'b1))) begin
                    state_nxt    = IDLE;
                    gnt_nxt      = '0;
                    last_gnt_nxt = gnt_idx;
                end else if (w_en) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            half_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= gnt_idx_nxt;
            last_gnt <= last_gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
            half_q   <= half_q_nxt;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            err_cnt <= '0;
        end else if (write_error && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic        half_full;
    logic        write_error;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        w_en;
    logic [7:0]  data_in;
    logic        busy;
    logic [7:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .full(full), .half_full(half_full), .write_error(write_error),
        .gnt(gnt), .ack(ack), .w_en(w_en), .data_in(data_in),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 wclk = ~wclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset;
        wrst_n      = 1'b0;
        req         = '0;
        full        = 1'b0;
        half_full   = 1'b0;
        write_error = 1'b0;
        req_data    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        repeat (2) step();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset;
        wrst_n = 1'b0;
        req = 4'b1111; full = 1'b0; half_full = 1'b0; write_error = 1'b1;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        repeat (2) step();
        @(negedge wclk);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL reset_w_en got=%b exp=0", w_en); end
        vectors++; if (data_in !== 8'h00) begin miscompares++; $display("FAIL reset_data_in got=%h exp=00", data_in); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (err_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        step();
        req = '0; write_error = 1'b0;
    endtask

    // req=0001 held: idle, 4 beats, one idle cycle, regrant to requester 0
    task automatic test_single;
        logic [3:0] eg;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            @(negedge wclk);
            eg = (c == 0 || c == 5) ? 4'b0000 : 4'b0001;
            vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            vectors++; if (ack !== eg) begin miscompares++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, ack, eg); end
            vectors++; if (w_en !== (eg != 4'b0000)) begin miscompares++; $display("FAIL single_w_en c=%0d got=%b exp=%b", c, w_en, (eg != 4'b0000)); end
            vectors++; if (data_in !== ((eg != 4'b0000) ? 8'hA0 : 8'h00)) begin miscompares++; $display("FAIL single_data c=%0d got=%h", c, data_in); end
            step();
        end
    endtask

    // all requesting: grants 0,1,2,3,0 of 4 beats each, one idle cycle between
    task automatic test_round_robin;
        logic [3:0] eg;
        logic [7:0] ed;
        int p, g;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 26; c++) begin
            @(negedge wclk);
            eg = 4'b0000;
            ed = 8'h00;
            if (c > 0) begin
                p = (c - 1) % 5;
                g = ((c - 1) / 5) % 4;
                if (p < 4) begin
                    eg = 4'b0001 << g;
                    ed = 8'hA0 + 8'(g * 17);
                end
            end
            vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            vectors++; if (w_en !== (eg != 4'b0000)) begin miscompares++; $display("FAIL rr_w_en c=%0d got=%b exp=%b", c, w_en, (eg != 4'b0000)); end
            vectors++; if (data_in !== ed) begin miscompares++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, data_in, ed); end
            vectors++; if ($countones(gnt) > 1 || $countones(ack) > 1) begin miscompares++; $display("FAIL rr_onehot c=%0d gnt=%b ack=%b", c, gnt, ack); end
            step();
        end
    endtask

    // requester 2, full for 5 cycles after beat 2
    task automatic test_full_stall;
        do_reset();
        req = 4'b0100;
        step();
        for (int b = 1; b <= 2; b++) begin
            @(negedge wclk);
            vectors++; if (w_en !== 1'b1 || gnt !== 4'b0100) begin miscompares++; $display("FAIL stall_pre b=%0d w_en=%b gnt=%b exp 1/0100", b, w_en, gnt); end
            vectors++; if (data_in !== 8'hC2) begin miscompares++; $display("FAIL stall_data b=%0d got=%h exp=c2", b, data_in); end
            step();
        end
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            vectors++; if (w_en !== 1'b0 || ack !== 4'b0000) begin miscompares++; $display("FAIL stall_hold i=%0d w_en=%b ack=%b exp 0/0000", i, w_en, ack); end
            vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL stall_gnt i=%0d got=%b exp=0100", i, gnt); end
            step();
        end
        full = 1'b0;
        for (int b = 3; b <= 4; b++) begin
            @(negedge wclk);
            vectors++; if (w_en !== 1'b1 || ack !== 4'b0100) begin miscompares++; $display("FAIL stall_post b=%0d w_en=%b ack=%b exp 1/0100", b, w_en, ack); end
            step();
        end
        @(negedge wclk);
        vectors++; if (gnt !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL stall_release gnt=%b busy=%b exp 0000/0", gnt, busy); end
    endtask

    // half_full at grant edge: burst limited to 2 beats
    task automatic test_half;
        do_reset();
        half_full = 1'b1;
        req = 4'b0010;
        step();
        half_full = 1'b0;
        for (int b = 1; b <= 2; b++) begin
            @(negedge wclk);
            vectors++; if (w_en !== 1'b1 || gnt !== 4'b0010) begin miscompares++; $display("FAIL half_beat b=%0d w_en=%b gnt=%b exp 1/0010", b, w_en, gnt); end
            step();
        end
        @(negedge wclk);
        vectors++; if (gnt !== 4'b0000 || w_en !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL half_release gnt=%b w_en=%b busy=%b exp 0000/0/0", gnt, w_en, busy); end
    endtask

    // req[1] dropped after beat 1, pending req[3] wins next
    task automatic test_drop;
        do_reset();
        req = 4'b1010;
        step();
        @(negedge wclk);
        vectors++; if (gnt !== 4'b0010 || w_en !== 1'b1) begin miscompares++; $display("FAIL drop_first gnt=%b w_en=%b exp 0010/1", gnt, w_en); end
        step();
        req = 4'b1000;
        @(negedge wclk);
        vectors++; if (w_en !== 1'b0 || gnt !== 4'b0010) begin miscompares++; $display("FAIL drop_edge w_en=%b gnt=%b exp 0/0010", w_en, gnt); end
        step();
        @(negedge wclk);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL drop_idle got=%b exp=0000", gnt); end
        step();
        @(negedge wclk);
        vectors++; if (gnt !== 4'b1000 || data_in !== 8'hD3) begin miscompares++; $display("FAIL drop_next gnt=%b data=%h exp 1000/d3", gnt, data_in); end
    endtask

    // error counter saturation, then async reset in mid-burst
    task automatic test_err_and_reset;
        do_reset();
        write_error = 1'b1;
        repeat (100) step();
        write_error = 1'b0;
        @(negedge wclk);
        vectors++; if (err_cnt !== 8'd100) begin miscompares++; $display("FAIL err_100 got=%0d exp=100", err_cnt); end
        step();
        write_error = 1'b1;
        repeat (200) step();
        write_error = 1'b0;
        @(negedge wclk);
        vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL err_sat got=%0d exp=255", err_cnt); end
        step();
        req = 4'b0001;
        step();
        step();
        @(negedge wclk);
        vectors++; if (w_en !== 1'b1) begin miscompares++; $display("FAIL midrst_pre w_en=%b exp=1", w_en); end
        #1 wrst_n = 1'b0;
        #1;
        vectors++; if (w_en !== 1'b0 || ack !== 4'b0000) begin miscompares++; $display("FAIL midrst_w_en w_en=%b ack=%b exp 0/0000", w_en, ack); end
        vectors++; if (err_cnt !== 8'd0 || gnt !== 4'b0000) begin miscompares++; $display("FAIL midrst_state err_cnt=%0d gnt=%b exp 0/0000", err_cnt, gnt); end
        step();
        req = '0;
        wrst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_half();
        test_drop();
        test_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Param DATA_WIDTH, default 8: width of each requester's data word and of the FIFO write data.
REQ-002 Param NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-003 Param MAX_BURST, default 4: maximum beats per grant; legal range 2..16.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: wclk is the only clock and wrst_n is the only reset.
REQ-005 wclk  in  1  clock; FIFO write-side clock, rising edge.
REQ-006 wrst_n  in  1  reset; asynchronous assert, active low, released synchronously by the environment.
REQ-007 req  in  NUM_REQ  per-requester write request, level, held while data is pending.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  packed data; slice i is requester i's data.
REQ-009 full  in  1  FIFO full flag, wclk domain.
REQ-010 half_full  in  1  FIFO half-full flag, wclk domain.
REQ-011 write_error  in  1  FIFO write-error pulse, wclk domain.
REQ-012 gnt  out  NUM_REQ  one-hot registered grant; all zero when idle.
REQ-013 ack  out  NUM_REQ  one-hot beat accept; requester i presents its next word after a cycle with ack[i]=1.
REQ-014 w_en  out  1  FIFO write enable.
REQ-015 data_in  out  DATA_WIDTH  FIFO write data.
REQ-016 busy  out  1  high while state is not IDLE.
REQ-017 err_cnt  out  8  saturating count of write_error pulses.

Function
REQ-018 FSM states: IDLE, BURST.
- IDLE -> BURST on the edge where any req bit is 1.
- BURST -> IDLE on the burst-termination conditions in REQ-024.
REQ-019 Arbitration in IDLE is round-robin:
- The winner is the first asserted req index searching upward, with wrap, from last_gnt+1.
- The winner is loaded into gnt on the same edge as the IDLE -> BURST transition.
REQ-020 Grant-to-first-write latency is one cycle: req rises at edge N, gnt is valid after N, and the first w_en is possible in cycle N+1.
REQ-021 In BURST, w_en = req[g] AND NOT full, combinational from registered gnt, req and full.
- ack[g] equals w_en.
- All other ack bits are 0.
REQ-022 data_in SHALL equal the req_data slice of the granted index whenever gnt is nonzero, and 0 otherwise.
REQ-023 beat_cnt counts w_en cycles within the current grant.
- It clears on entering BURST.
- Burst limit L = MAX_BURST, or MAX_BURST/2 if half_full was 1 on the grant edge.
REQ-024 BURST terminates (gnt cleared, state -> IDLE, last_gnt <= g) on the edge where either:
- a write occurs with beat_cnt = L-1; or
- req[g] = 0.
REQ-025 full held high in BURST SHALL stall: no w_en and no ack, beat_cnt and gnt unchanged, no timeout.
REQ-026 Re-arbitration requires one IDLE cycle; back-to-back grants are separated by exactly one cycle with gnt = 0.
REQ-027 A requester whose req drops and re-rises during another requester's grant waits its round-robin turn.
REQ-028 err_cnt increments on each wclk edge with write_error = 1 and saturates at 255.
REQ-029 Simultaneous requests SHALL never produce more than one gnt bit or ack bit set at once.

Reset
REQ-030 While wrst_n = 0:
- state = IDLE; gnt, ack, w_en, data_in, busy, beat_cnt and err_cnt are all 0.
- last_gnt = NUM_REQ-1, so requester 0 wins first.
REQ-031 Assertion of wrst_n in mid-burst SHALL drop w_en and ack asynchronously with no further write; the partial burst is lost.

Verification
REQ-032 Reset, then req=4'b0001 held, full=0, half_full=0 -> gnt=0001 one cycle later, 4 consecutive w_en/ack[0], gnt=0 for one cycle, then a new grant to requester 0.
REQ-033 req=4'b1111 held, full=0 -> grant order 0,1,2,3,0, each grant 4 beats, one idle cycle between grants, never two gnt bits set.
REQ-034 Requester 2 granted, full=1 for 5 cycles after beat 2 -> no w_en for those 5 cycles, then beats 3-4 complete, then release.
REQ-035 half_full=1 at grant edge, req=0010 held -> exactly 2 beats, then release.
REQ-036 req[1] dropped after beat 1 of a grant to requester 1 -> release on that edge, last_gnt=1, pending req[3] wins next.
REQ-037 300 write_error pulses -> err_cnt=255; wrst_n pulsed mid-burst -> w_en=0 immediately and err_cnt=0.
